// File: rtl/io_input_port_pkg.sv
// Shared definitions for the processor I/O ports: handshake FSM states and
// default FIFO geometry. The matching output port reuses this package.
package io_input_port_pkg;

   // Four-phase handshake states; encodings are fixed so both ports agree.
   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StOffer   = 2'd1,
      StWaitRel = 2'd2
   } hs_state_e;

   localparam int unsigned DEFAULT_DEPTH  = 8;
   localparam int unsigned DEFAULT_ADDR_W = 3;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with occupancy count. Pointers wrap modulo DEPTH; count runs
// 0..DEPTH so full and empty are unambiguous. Storage is not cleared.
module byte_fifo
   import io_input_port_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              push,
   input  logic              pop,
   input  logic [7:0]        wr_data,
   output logic [7:0]        rd_data,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};

   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]   count_q, count_d;
   logic              do_push, do_pop;

   // Requests that cannot be honoured are ignored here as a safety net.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem[rd_ptr_q];

   // Occupancy next state; simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_d = count_q;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
      end
   end

   // Storage write; deliberately has no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/io_input_port.sv
// Buffered input port: queues bytes from a valid/ready source and offers the
// oldest one to the processor with a four-phase hs/ack handshake.
module io_input_port
   import io_input_port_pkg::*;
#(
   parameter int unsigned DEPTH  = DEFAULT_DEPTH,
   parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
   input  logic            g_clk,
   input  logic            g_clr,
   input  logic [7:0]      src_data,
   input  logic            src_valid,
   output logic            src_ready,
   output logic [7:0]      input_bus,
   output logic            in_dev_hs,
   input  logic            in_dev_ack,
   output logic [ADDR_W:0] fifo_count,
   output logic            drop_err,
   input  logic            err_clr
);

   hs_state_e  state_q, state_d;
   logic [7:0] head;
   logic       full, empty;
   logic       push, pop, load_bus;

   assign src_ready = !full;
   assign push      = src_valid && !full;

   byte_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (g_clk),
      .clr     (g_clr),
      .push    (push),
      .pop     (pop),
      .wr_data (src_data),
      .rd_data (head),
      .count   (fifo_count),
      .full    (full),
      .empty   (empty)
   );

   // Handshake state register.
   always_ff @(posedge g_clk or posedge g_clr) begin
      if (g_clr) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Handshake next state. Ack high in idle is ignored so a stuck ack cannot
   // pop or start an offer. In WaitRel the pop has already happened, so
   // empty reflects the post-pop count.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (!empty && !in_dev_ack) state_d = StOffer;
         StOffer:   if (in_dev_ack)            state_d = StWaitRel;
         StWaitRel: if (!in_dev_ack)           state_d = empty ? StIdle : StOffer;
         default:   state_d = StIdle;
      endcase
   end

   // Handshake controls: pop on ack during an offer, latch head on offer entry.
   always_comb begin
      pop      = (state_q == StOffer) && in_dev_ack;
      load_bus = (state_d == StOffer) && (state_q != StOffer);
   end

   // Registered processor-facing outputs; hs falls asynchronously on clear.
   always_ff @(posedge g_clk or posedge g_clr) begin
      if (g_clr) begin
         input_bus <= 8'h00;
         in_dev_hs <= 1'b0;
      end else begin
         if (load_bus) input_bus <= head;
         in_dev_hs <= (state_d == StOffer);
      end
   end

   // Sticky overflow flag; a drop at the same edge as err_clr wins.
   always_ff @(posedge g_clk or posedge g_clr) begin
      if (g_clr)                 drop_err <= 1'b0;
      else if (src_valid && full) drop_err <= 1'b1;
      else if (err_clr)          drop_err <= 1'b0;
   end

endmodule
